// File: rtl/cmp_sweep_if.sv
// Bundle of the signals between the sweep checker and the comparator under test.
// The master modport is the checker side; the slave modport is the comparator
// / host side. The fail_a/fail_b capture signals exist only when
// CMP_STOP_ON_ERR_EN is defined.
interface cmp_sweep_if #(
    parameter int WIDTH = 2,
    parameter int ERR_W = 8
);
    logic             start;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             aeqb_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
`ifdef CMP_STOP_ON_ERR_EN
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;

    modport master (
        input  start, aeqb_in,
        output a_out, b_out, busy, done, pass, err_cnt, fail_a, fail_b
    );
    modport slave (
        output start, aeqb_in,
        input  a_out, b_out, busy, done, pass, err_cnt, fail_a, fail_b
    );
`else
    modport master (
        input  start, aeqb_in,
        output a_out, b_out, busy, done, pass, err_cnt
    );
    modport slave (
        output start, aeqb_in,
        input  a_out, b_out, busy, done, pass, err_cnt
    );
`endif
endinterface

// File: rtl/cmp_sweep_checker.sv
// Exhaustive stimulus generator and response checker for a WIDTH-bit equality
// comparator. Every (a,b) pair is held for SETTLE cycles, then aeqb is sampled
// in a one-cycle CHECK state and compared against a==b. Mismatches are counted
// in a saturating counter.
// Optional feature macro: CMP_STOP_ON_ERR_EN -- stop at the first mismatch and
// capture the failing operands on fail_a/fail_b.
module cmp_sweep_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 4,
    parameter int ERR_W  = 8
) (
    input logic         clk,
    input logic         reset_n,
    cmp_sweep_if.master bus
);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [WIDTH-1:0] OPND_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             mismatch;
    logic             stop_now;
    logic             last_vec;
`ifdef CMP_STOP_ON_ERR_EN
    logic [WIDTH-1:0] fail_a_q, fail_a_d;
    logic [WIDTH-1:0] fail_b_q, fail_b_d;
`endif

    // Response check: the comparator output is treated as combinational on a/b.
    assign mismatch = (bus.aeqb_in != (a_q == b_q));
    assign last_vec = (a_q == OPND_MAX) && (b_q == OPND_MAX);

    // Next-state, counter, operand and error-count logic for the sweep FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        err_d    = err_q;
        stop_now = 1'b0;
`ifdef CMP_STOP_ON_ERR_EN
        fail_a_d = fail_a_q;
        fail_b_d = fail_b_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                    a_d     = '0;
                    b_d     = '0;
                    err_d   = '0;
`ifdef CMP_STOP_ON_ERR_EN
                    fail_a_d = '0;
                    fail_b_d = '0;
`endif
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch && (err_q != ERR_MAX)) begin
                    err_d = err_q + ERR_W'(1);
                end
`ifdef CMP_STOP_ON_ERR_EN
                // First mismatch ends the sweep; err_q is still zero here.
                if (mismatch) begin
                    stop_now = 1'b1;
                    fail_a_d = a_q;
                    fail_b_d = b_q;
                    err_d    = ERR_W'(1);
                end
`endif
                if (last_vec || stop_now) begin
                    state_d = ST_DONE;
                    a_d     = '0;
                    b_d     = '0;
                end else begin
                    // b is the inner loop; its wrap carries into a.
                    state_d = ST_SETTLE;
                    b_d     = b_q + WIDTH'(1);
                    if (b_q == OPND_MAX) begin
                        a_d = a_q + WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any sweep with no residue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

`ifdef CMP_STOP_ON_ERR_EN
    // Failing-operand capture registers, held until the next start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_a_q <= '0;
            fail_b_q <= '0;
        end else begin
            fail_a_q <= fail_a_d;
            fail_b_q <= fail_b_d;
        end
    end

    assign bus.fail_a = fail_a_q;
    assign bus.fail_b = fail_b_q;
`endif

    assign bus.a_out   = a_q;
    assign bus.b_out   = b_q;
    assign bus.busy    = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.pass    = (state_q == ST_DONE) && (err_q == '0);
    assign bus.err_cnt = err_q;
endmodule
